// File: rtl/rca_adder_if.sv
// Bus for the ripple-carry adder: operand/request side plus registered result side.
// The ovf signal only exists when RCA_OVERFLOW_EN is defined.
interface rca_adder_if #(parameter int WIDTH = 4);
   logic             in_valid;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic             c_in;
   logic [WIDTH-1:0] S;
   logic             c_out;
   logic             out_valid;
   logic [WIDTH-1:0] carry;
`ifdef RCA_OVERFLOW_EN
   logic             ovf;
`endif

   // master drives operands and observes results
   modport master (
      output in_valid, A, B, c_in,
`ifdef RCA_OVERFLOW_EN
      input  ovf,
`endif
      input  S, c_out, out_valid, carry
   );

   // slave is the adder itself
   modport slave (
      input  in_valid, A, B, c_in,
`ifdef RCA_OVERFLOW_EN
      output ovf,
`endif
      output S, c_out, out_valid, carry
   );
endinterface

// File: rtl/rca_adder.sv
// Parameterised ripple-carry adder with one registered output stage.
// Sum is built from a chain of full-adder cells, carry rippling LSB to MSB.
// Optional feature: define RCA_OVERFLOW_EN to add the registered signed-overflow flag ovf.

// Single-bit full adder cell
module rca_fa (
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic s,
   output logic co
);
   assign s  = a ^ b ^ ci;
   assign co = (a & b) | (a & ci) | (b & ci);
endmodule

module rca_adder #(
   parameter int WIDTH = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   rca_adder_if.slave  bus
);
   // k[i] is the carry into bit i; k[WIDTH] is the final carry out
   logic [WIDTH:0]   k;
   logic [WIDTH-1:0] s_c;

   logic [WIDTH-1:0] s_q;
   logic [WIDTH-1:0] carry_q;
   logic             vld_q;

   assign k[0] = bus.c_in;

   generate
      for (genvar i = 0; i < WIDTH; i++) begin : g_bit
         rca_fa u_fa (
            .a  (bus.A[i]),
            .b  (bus.B[i]),
            .ci (k[i]),
            .s  (s_c[i]),
            .co (k[i+1])
         );
      end
   endgenerate

   // result registers: capture on in_valid, otherwise hold
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s_q     <= '0;
         carry_q <= '0;
      end else if (bus.in_valid) begin
         s_q     <= s_c;
         carry_q <= k[WIDTH:1];
      end
   end

   // valid flag follows in_valid with one cycle of delay
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) vld_q <= 1'b0;
      else        vld_q <= bus.in_valid;
   end

   assign bus.S         = s_q;
   assign bus.carry     = carry_q;
   assign bus.c_out     = carry_q[WIDTH-1];
   assign bus.out_valid = vld_q;

`ifdef RCA_OVERFLOW_EN
   logic ovf_q;

   // signed overflow: carry into MSB differs from carry out of MSB
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)            ovf_q <= 1'b0;
      else if (bus.in_valid) ovf_q <= k[WIDTH-1] ^ k[WIDTH];
   end

   assign bus.ovf = ovf_q;
`endif
endmodule

// File: tb/tb_rca_adder.sv
// Self-checking bench for rca_adder: directed vectors, hold, async reset,
// randomized traffic and an exhaustive back-to-back sweep against an arithmetic model.
module tb_rca_adder;
   localparam int W = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   rca_adder_if #(.WIDTH(W)) bus ();

   rca_adder #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_pass = 0;

   // expected registered state
   logic [W-1:0] exp_s;
   logic         exp_co;
   logic [W-1:0] exp_carry;
   logic         exp_ovf;
   logic         exp_vld;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic model_reset();
      exp_s = '0; exp_co = 1'b0; exp_carry = '0; exp_ovf = 1'b0; exp_vld = 1'b0;
   endtask

   // arithmetic reference: carries from truncated sums, overflow from signed range
   task automatic model(input logic v, input logic [W-1:0] a, input logic [W-1:0] b, input logic ci);
      int sum, m, sa, sb, ss;
      exp_vld = v;
      if (v) begin
         sum    = int'(a) + int'(b) + int'(ci);
         exp_s  = W'(sum % (1 << W));
         exp_co = (sum >> W) != 0;
         for (int i = 0; i < W; i++) begin
            m = (1 << (i + 1)) - 1;
            exp_carry[i] = ((((int'(a) & m) + (int'(b) & m) + int'(ci)) >> (i + 1)) & 1) != 0;
         end
         sa = a[W-1] ? int'(a) - (1 << W) : int'(a);
         sb = b[W-1] ? int'(b) - (1 << W) : int'(b);
         ss = sa + sb + int'(ci);
         exp_ovf = (ss > (1 << (W - 1)) - 1) || (ss < -(1 << (W - 1)));
      end
   endtask

   task automatic check_out(input string tag);
      chk({tag, ".S"},         32'(bus.S),         32'(exp_s));
      chk({tag, ".c_out"},     32'(bus.c_out),     32'(exp_co));
      chk({tag, ".carry"},     32'(bus.carry),     32'(exp_carry));
      chk({tag, ".out_valid"}, 32'(bus.out_valid), 32'(exp_vld));
`ifdef RCA_OVERFLOW_EN
      chk({tag, ".ovf"},       32'(bus.ovf),       32'(exp_ovf));
`endif
   endtask

   // drive one cycle of inputs, advance past the edge, check against the model
   task automatic step(input string tag, input logic v, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic ci);
      bus.in_valid = v; bus.A = a; bus.B = b; bus.c_in = ci;
      @(posedge clk); #1;
      model(v, a, b, ci);
      check_out(tag);
   endtask

   // directed vectors: a, b, c_in, expected S, expected c_out
   logic [W-1:0] d_a  [8] = '{4'b0001, 4'b1011, 4'b0110, 4'b1111, 4'b0001, 4'b1011, 4'b0110, 4'b1111};
   logic [W-1:0] d_b  [8] = '{4'b0111, 4'b0101, 4'b1000, 4'b1111, 4'b0111, 4'b0101, 4'b1000, 4'b1111};
   logic         d_ci [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
   logic [W-1:0] d_s  [8] = '{4'b1000, 4'b0000, 4'b1110, 4'b1110, 4'b1001, 4'b0001, 4'b1111, 4'b1111};
   logic         d_co [8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

   initial begin
      logic [W-1:0] hs;
      logic         hc;
      bus.in_valid = 1'b0; bus.A = '0; bus.B = '0; bus.c_in = 1'b0;
      model_reset();

      // reset state
      repeat (2) @(posedge clk);
      #1;
      check_out("reset");
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // directed sums with literal expectations, back-to-back
      for (int i = 0; i < 8; i++) begin
         step("dir", 1'b1, d_a[i], d_b[i], d_ci[i]);
         chk("dir.lit_S",  32'(bus.S),     32'(d_s[i]));
         chk("dir.lit_co", 32'(bus.c_out), 32'(d_co[i]));
      end

      // full ripple through every bit
      step("ripple", 1'b1, 4'b1111, 4'b0000, 1'b1);
      chk("ripple.lit_carry", 32'(bus.carry), 32'hF);
      chk("ripple.lit_S",     32'(bus.S),     32'h0);

`ifdef RCA_OVERFLOW_EN
      step("ovf", 1'b1, 4'b0111, 4'b0001, 1'b0);
      chk("ovf.lit_ovf", 32'(bus.ovf), 32'h1);
      chk("ovf.lit_S",   32'(bus.S),   32'h8);
`endif

      // hold: result stays while in_valid is low and operands change
      step("hold_load", 1'b1, 4'b0101, 4'b0110, 1'b1);
      hs = bus.S; hc = bus.c_out;
      for (int i = 0; i < 3; i++) begin
         step("hold", 1'b0, W'($urandom), W'($urandom), 1'($urandom));
         chk("hold.lit_S",  32'(bus.S),     32'(4'b1100));
         chk("hold.lit_co", 32'(bus.c_out), 32'(1'b0));
      end

      // async reset between edges while a result is valid
      step("pre_rst", 1'b1, 4'b1001, 4'b1001, 1'b1);
      #2;
      rst_n = 1'b0;
      bus.in_valid = 1'b0;
      #1;
      model_reset();
      check_out("async_rst");
      @(negedge clk);
      rst_n = 1'b1;
      step("post_rst", 1'b1, 4'b0011, 4'b0100, 1'b0);
      chk("post_rst.lit_S", 32'(bus.S), 32'(4'b0111));

      // randomized traffic with random gaps
      for (int i = 0; i < 200; i++)
         step("rand", 1'($urandom_range(0, 3) != 0), W'($urandom), W'($urandom), 1'($urandom));

      // exhaustive sweep, streamed back-to-back
      for (int x = 0; x < 512; x++)
         step("exh", 1'b1, x[3:0], x[7:4], x[8]);
      step("drain", 1'b0, 4'b0000, 4'b0000, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   // global watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end
endmodule

// File: doc/rca_adder.md
Name: rca_adder

Overview:
- Parameterised ripple-carry adder. Computes S = A + B + c_in using an explicit chain of per-bit full-adder cells, with carry rippling LSB to MSB.
- Sum, carry-out and a valid flag are registered, giving one clock cycle of latency.
- Serves as the basic adder element in datapath arithmetic and as the reference for comparing the timing of carry-lookahead variants.

Parameters:
- WIDTH, 4, operand and sum width in bits; legal range is 1 or more.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  A, B and c_in are valid this cycle.
- A  input  WIDTH  operand A, unsigned (also read as two's complement for the optional overflow flag).
- B  input  WIDTH  operand B.
- c_in  input  1  carry into bit 0.
- S  output  WIDTH  registered sum bits, equal to (A+B+c_in) mod 2^WIDTH.
- c_out  output  1  registered carry out of bit WIDTH-1.
- out_valid  output  1  S and c_out hold a new result.
- carry  output  WIDTH  registered internal carry vector; carry[i] is the carry out of bit i, and carry[WIDTH-1] equals c_out.

Behaviour:
- Combinational core:
  - Bit i is a full adder: s_i = a_i ^ b_i ^ k_i, and k_(i+1) = a_i&b_i | a_i&k_i | b_i&k_i.
  - k_0 = c_in.
  - Built structurally as WIDTH full-adder cells from a generate loop. No behavioural "+" on the full vector.
- Register stage:
  - On a clk rising edge with in_valid=1: S, c_out and carry capture the core outputs, and out_valid goes to 1.
  - On a clk rising edge with in_valid=0: S, c_out and carry hold their values, and out_valid goes to 0.
- Latency and throughput:
  - Exactly one cycle. A result sampled at edge n is visible after edge n.
  - Full throughput: back-to-back in_valid cycles give back-to-back results.
  - No backpressure; the consumer must accept out_valid pulses.
- Reset:
  - rst_n=0 immediately clears S=0, c_out=0, carry=0 and out_valid=0, independent of clk.
  - Asserting reset mid-stream discards any in-flight result.
  - After release, the first edge with in_valid=1 produces a result normally.
- Arithmetic rules:
  - {c_out,S} is the exact (WIDTH+1)-bit unsigned sum, in the range 0 to 2^(WIDTH+1)-1.
  - Wrap-around: for all-ones + all-ones + c_in, S = all-ones minus 1 + c_in and c_out = 1.
  - X on an input propagates only through the affected bits; no special handling.
- No other state, no FSM.

Optional Feature:
- Macro: RCA_OVERFLOW_EN.
- With the macro defined:
  - Adds output ovf (1 bit, registered), equal to the carry into bit WIDTH-1 XOR the carry out of bit WIDTH-1. This is signed two's-complement overflow.
  - ovf updates with the same in_valid rule as S.
  - ovf resets to 0.
- Without the macro: the ovf port and its logic do not exist. All other behaviour is identical.

Test Plan:
- Basic sums, c_in=0, WIDTH=4, in_valid=1: A=0001,B=0111 -> S=1000,c_out=0. A=1011,B=0101 -> S=0000,c_out=1. A=0110,B=1000 -> S=1110,c_out=0. A=1111,B=1111 -> S=1110,c_out=1. Each result appears one cycle after its inputs, with out_valid=1.
- Same operands with c_in=1 -> S=1001,c_out=0; S=0001,c_out=1; S=1111,c_out=0; S=1111,c_out=1.
- Full ripple: A=1111,B=0000,c_in=1 -> S=0000,c_out=1,carry=1111. With RCA_OVERFLOW_EN: A=0111,B=0001,c_in=0 -> S=1000,ovf=1.
- Hold: present a result, then drive in_valid=0 with changing A/B -> S and c_out unchanged, out_valid=0 from the next edge.
- Asynchronous reset: assert rst_n=0 between clock edges while out_valid=1 -> S, c_out, carry and out_valid are 0 immediately. Release and apply A=0011,B=0100,c_in=0 -> S=0111 one cycle later.
- Exhaustive: all 512 combinations of A, B and c_in, streamed back-to-back -> {c_out,S} equals A+B+c_in for every case, with out_valid high continuously.
